// File: rtl/smvm_result_collector.sv
// smvm_result_collector
// Re-pairs the SMVM core's serial 12-bit result halves (high first, then low)
// into full 24-bit row results and tags each with its row index. Results go
// through a small first-word-fall-through FIFO to a valid/ready host port.
// The block reports done once the configured number of rows has been
// collected and the FIFO has drained.
module smvm_result_collector #(
  parameter int HALF_W    = 12,
  parameter int ROW_BITS  = 9,
  parameter int DEPTH     = 8,
  parameter int ADDR_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ROW_BITS-1:0]   rows_cfg,
  input  logic                  in_valid,
  input  logic [HALF_W-1:0]     data_in,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [2*HALF_W-1:0]   data_out,
  output logic [ROW_BITS-1:0]   row_idx,
  output logic [ADDR_BITS:0]    fifo_count,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int ENTRY_W = ROW_BITS + 2 * HALF_W;
  localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Pairing and job bookkeeping
  logic [HALF_W-1:0]   r_hi;
  logic                r_half_sel;
  logic [ROW_BITS-1:0] r_target;
  logic [ROW_BITS-1:0] r_rows_rcvd;
  logic                r_overflow;

  // FIFO storage: each entry is {row index, high half, low half}
  logic [ENTRY_W-1:0]   r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_count;

  logic               w_start_ok;
  logic               w_pair_done;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic [ENTRY_W-1:0] w_head;

  // Start is honoured only between jobs; a start during COLLECT/DRAIN is ignored.
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_pair_done = (r_state == S_COLLECT) && in_valid && r_half_sel;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FULL_COUNT);
  assign w_pop       = !w_empty && out_ready;
  // A full FIFO still takes the new result when the head leaves in the same cycle.
  assign w_push      = w_pair_done && (!w_full || w_pop);
  assign w_head      = r_mem[r_rd_ptr];

  // Head is shown only while valid so every output reads 0 after reset.
  assign out_valid  = !w_empty;
  assign data_out   = w_empty ? '0 : w_head[2*HALF_W-1:0];
  assign row_idx    = w_empty ? '0 : w_head[ENTRY_W-1 -: ROW_BITS];
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and status outputs
  // NOTE: every signal written here gets a default first, otherwise a path
  // that skips an assignment would infer a latch.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_COLLECT;
      end
      S_COLLECT: begin
        busy = 1'b1;
        if (r_rows_rcvd == r_target) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_empty) w_next_state = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_next_state = S_COLLECT;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Job setup on start, half pairing, row counting and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi        <= '0;
      r_half_sel  <= 1'b0;
      r_target    <= '0;
      r_rows_rcvd <= '0;
      r_overflow  <= 1'b0;
    end else if (w_start_ok) begin
      r_target    <= rows_cfg;
      r_rows_rcvd <= '0;
      r_half_sel  <= 1'b0;
      r_overflow  <= 1'b0;
    end else if ((r_state == S_COLLECT) && in_valid) begin
      if (!r_half_sel) begin
        r_hi       <= data_in;
        r_half_sel <= 1'b1;
      end else begin
        // The row counts even when dropped so the job always terminates.
        r_half_sel  <= 1'b0;
        r_rows_rcvd <= r_rows_rcvd + 1'b1;
        if (!w_push) r_overflow <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // FIFO storage write
  // NOTE: the array has no reset; occupancy gates every read, so stale
  // contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_rows_rcvd, r_hi, data_in};
  end

endmodule
